// File: rtl/matrix_mem_banked_pkg.sv
// Shared CalcKit definitions: default geometry, clear-engine states and
// the element address helper used by the storage block and the ALU.
`default_nettype none

package calckit_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_SLOTS = 4;
    localparam int MAX_DIM   = 5;
    localparam int SLOT_W    = 2;
    localparam int DIM_W     = 3;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Evaluated in 32 bits so no partial product is truncated; callers narrow.
    function automatic logic [31:0] addr_of(input logic [31:0] slot,
                                            input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] max_dim = 32'(MAX_DIM));
        return slot * max_dim * max_dim + row * max_dim + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_mem_banked_clr_engine.sv
// Background slot-clear sequencer: walks every element of one slot writing
// zero, then spends one cycle wiping the slot's dimensions.
`default_nettype none

module matrix_clr_engine #(
    parameter  int SLOT_W  = 2,
    parameter  int MAX_DIM = 5,
    localparam int IDX_W   = $clog2(MAX_DIM * MAX_DIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    input  logic [SLOT_W-1:0] clr_slot_i,
    output logic              busy_o,
    output logic              wr_en_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              dim_clr_o
);
    import calckit_pkg::*;

    localparam int N_ELEM = MAX_DIM * MAX_DIM;

    clr_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    slot_d  = clr_slot_i;
                    idx_d   = '0;
                    state_d = CLR_CLEAR;
                end
            end
            CLR_CLEAR: begin
                if (idx_q == IDX_W'(N_ELEM - 1)) begin
                    state_d = CLR_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

    assign busy_o    = (state_q != CLR_IDLE);
    assign wr_en_o   = (state_q == CLR_CLEAR);
    assign dim_clr_o = (state_q == CLR_DONE);
    assign slot_o    = slot_q;
    assign idx_o     = idx_q;

endmodule

`default_nettype wire

// File: rtl/matrix_mem_banked.sv
// Dual-ported matrix storage: user entry/display port, ALU operand/result
// port, per-slot dimensions and a background slot-clear engine.
`default_nettype none

module matrix_mem_banked #(
    parameter int DATA_W    = calckit_pkg::DATA_W,
    parameter int NUM_SLOTS = calckit_pkg::NUM_SLOTS,
    parameter int MAX_DIM   = calckit_pkg::MAX_DIM,
    parameter int SLOT_W    = calckit_pkg::SLOT_W,
    parameter int DIM_W     = calckit_pkg::DIM_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SLOT_W-1:0]    u_slot_i,
    input  logic [DIM_W-1:0]     u_row_i,
    input  logic [DIM_W-1:0]     u_col_i,
    input  logic [DATA_W-1:0]    u_wdata_i,
    input  logic                 u_we_i,
    input  logic                 u_re_i,
    output logic [DATA_W-1:0]    u_rdata_o,
    output logic                 u_rvalid_o,
    input  logic [DIM_W-1:0]     u_dim_m_i,
    input  logic [DIM_W-1:0]     u_dim_n_i,
    input  logic                 u_dim_we_i,
    output logic [DIM_W-1:0]     u_cur_m_o,
    output logic [DIM_W-1:0]     u_cur_n_o,
    input  logic [SLOT_W-1:0]    a_rd_slot_i,
    input  logic [DIM_W-1:0]     a_rd_row_i,
    input  logic [DIM_W-1:0]     a_rd_col_i,
    input  logic                 a_re_i,
    output logic [DATA_W-1:0]    a_rdata_o,
    output logic                 a_rvalid_o,
    output logic [DIM_W-1:0]     a_cur_m_o,
    output logic [DIM_W-1:0]     a_cur_n_o,
    input  logic [SLOT_W-1:0]    a_wr_slot_i,
    input  logic [DIM_W-1:0]     a_wr_row_i,
    input  logic [DIM_W-1:0]     a_wr_col_i,
    input  logic [DATA_W-1:0]    a_wdata_i,
    input  logic                 a_we_i,
    input  logic [DIM_W-1:0]     a_res_m_i,
    input  logic [DIM_W-1:0]     a_res_n_i,
    input  logic                 a_dim_we_i,
    input  logic                 clr_req_i,
    input  logic [SLOT_W-1:0]    clr_slot_i,
    output logic                 clr_busy_o,
    output logic [NUM_SLOTS-1:0] slot_valid_o,
    output logic                 err_oob_o
);
    import calckit_pkg::*;

    localparam int DEPTH = NUM_SLOTS * MAX_DIM * MAX_DIM;
    localparam int IW    = $clog2(DEPTH);
    localparam int AW    = IW + 1;
    localparam int IDX_W = $clog2(MAX_DIM * MAX_DIM);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [NUM_SLOTS-1:0][DIM_W-1:0] dims_m_q, dims_n_q;
    logic [NUM_SLOTS-1:0]            slot_valid_q;
    logic                            err_q, err_d;
    logic [DATA_W-1:0]               u_rdata_q, a_rdata_q;
    logic                            u_rvalid_q, a_rvalid_q;

    logic              w_clr_busy, w_clr_we, w_clr_dim;
    logic [SLOT_W-1:0] w_clr_slot;
    logic [IDX_W-1:0]  w_clr_idx;

    matrix_clr_engine #(
        .SLOT_W  (SLOT_W),
        .MAX_DIM (MAX_DIM)
    ) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req_i),
        .clr_slot_i (clr_slot_i),
        .busy_o     (w_clr_busy),
        .wr_en_o    (w_clr_we),
        .slot_o     (w_clr_slot),
        .idx_o      (w_clr_idx),
        .dim_clr_o  (w_clr_dim)
    );

    logic [AW-1:0] w_u_addr, w_ard_addr, w_awr_addr, w_clr_addr;
    assign w_u_addr   = AW'(addr_of(32'(u_slot_i), 32'(u_row_i), 32'(u_col_i), 32'(MAX_DIM)));
    assign w_ard_addr = AW'(addr_of(32'(a_rd_slot_i), 32'(a_rd_row_i), 32'(a_rd_col_i), 32'(MAX_DIM)));
    assign w_awr_addr = AW'(addr_of(32'(a_wr_slot_i), 32'(a_wr_row_i), 32'(a_wr_col_i), 32'(MAX_DIM)));
    assign w_clr_addr = AW'(addr_of(32'(w_clr_slot), 32'd0, 32'(w_clr_idx), 32'(MAX_DIM)));

    // The depth compare is redundant for legal coordinates; it keeps a wide address from wrapping.
    logic w_u_oob, w_ard_oob, w_awr_oob;
    assign w_u_oob   = (32'(u_slot_i) >= NUM_SLOTS) || (32'(u_row_i) >= MAX_DIM) ||
                       (32'(u_col_i) >= MAX_DIM) || (w_u_addr >= AW'(DEPTH));
    assign w_ard_oob = (32'(a_rd_slot_i) >= NUM_SLOTS) || (32'(a_rd_row_i) >= MAX_DIM) ||
                       (32'(a_rd_col_i) >= MAX_DIM) || (w_ard_addr >= AW'(DEPTH));
    assign w_awr_oob = (32'(a_wr_slot_i) >= NUM_SLOTS) || (32'(a_wr_row_i) >= MAX_DIM) ||
                       (32'(a_wr_col_i) >= MAX_DIM) || (w_awr_addr >= AW'(DEPTH));

    logic w_u_dim_bad, w_a_dim_bad, w_u_blk, w_a_blk;
    assign w_u_dim_bad = (32'(u_slot_i) >= NUM_SLOTS) || (32'(u_dim_m_i) > MAX_DIM) ||
                         (32'(u_dim_n_i) > MAX_DIM);
    assign w_a_dim_bad = (32'(a_wr_slot_i) >= NUM_SLOTS) || (32'(a_res_m_i) > MAX_DIM) ||
                         (32'(a_res_n_i) > MAX_DIM);
    assign w_u_blk     = w_clr_busy && (u_slot_i == w_clr_slot);
    assign w_a_blk     = w_clr_busy && (a_wr_slot_i == w_clr_slot);

    logic w_u_we_ok, w_a_we_ok, w_u_dim_ok, w_a_dim_ok, w_err_set;
    assign w_u_we_ok  = u_we_i && !w_u_oob && !w_u_blk;
    assign w_a_we_ok  = a_we_i && !w_awr_oob && !w_a_blk;
    assign w_u_dim_ok = u_dim_we_i && !w_u_dim_bad && !w_u_blk;
    assign w_a_dim_ok = a_dim_we_i && !w_a_dim_bad && !w_a_blk;
    assign w_err_set  = ((u_we_i || u_re_i) && w_u_oob) || (a_re_i && w_ard_oob) ||
                        (a_we_i && w_awr_oob) || (u_dim_we_i && w_u_dim_bad) ||
                        (a_dim_we_i && w_a_dim_bad);
    assign err_d      = (err_q && !clr_req_i) || w_err_set;

    // Later assignments win at a shared address: clear over ALU over user.
    always_ff @(posedge clk) begin
        if (w_u_we_ok) mem_q[w_u_addr[IW-1:0]]   <= u_wdata_i;
        if (w_a_we_ok) mem_q[w_awr_addr[IW-1:0]] <= a_wdata_i;
        if (w_clr_we)  mem_q[w_clr_addr[IW-1:0]] <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dims_m_q     <= '0;
            dims_n_q     <= '0;
            slot_valid_q <= '0;
            err_q        <= 1'b0;
            u_rdata_q    <= '0;
            a_rdata_q    <= '0;
            u_rvalid_q   <= 1'b0;
            a_rvalid_q   <= 1'b0;
        end else begin
            err_q      <= err_d;
            u_rvalid_q <= u_re_i;
            a_rvalid_q <= a_re_i;
            if (u_re_i) u_rdata_q <= w_u_oob ? '0 : mem_q[w_u_addr[IW-1:0]];
            if (a_re_i) a_rdata_q <= w_ard_oob ? '0 : mem_q[w_ard_addr[IW-1:0]];
            if (w_u_dim_ok) begin
                dims_m_q[u_slot_i]     <= u_dim_m_i;
                dims_n_q[u_slot_i]     <= u_dim_n_i;
                slot_valid_q[u_slot_i] <= 1'b1;
            end
            if (w_a_dim_ok) begin
                dims_m_q[a_wr_slot_i]     <= a_res_m_i;
                dims_n_q[a_wr_slot_i]     <= a_res_n_i;
                slot_valid_q[a_wr_slot_i] <= 1'b1;
            end
            if (w_clr_dim) begin
                dims_m_q[w_clr_slot]     <= '0;
                dims_n_q[w_clr_slot]     <= '0;
                slot_valid_q[w_clr_slot] <= 1'b0;
            end
        end
    end

    assign u_cur_m_o    = (32'(u_slot_i) < NUM_SLOTS) ? dims_m_q[u_slot_i] : '0;
    assign u_cur_n_o    = (32'(u_slot_i) < NUM_SLOTS) ? dims_n_q[u_slot_i] : '0;
    assign a_cur_m_o    = (32'(a_rd_slot_i) < NUM_SLOTS) ? dims_m_q[a_rd_slot_i] : '0;
    assign a_cur_n_o    = (32'(a_rd_slot_i) < NUM_SLOTS) ? dims_n_q[a_rd_slot_i] : '0;
    assign u_rdata_o    = u_rdata_q;
    assign u_rvalid_o   = u_rvalid_q;
    assign a_rdata_o    = a_rdata_q;
    assign a_rvalid_o   = a_rvalid_q;
    assign clr_busy_o   = w_clr_busy;
    assign slot_valid_o = slot_valid_q;
    assign err_oob_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_mem_banked.sv
// Directed self-checking bench for matrix_mem_banked at default geometry.
`default_nettype none

module tb_matrix_mem_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  u_slot, a_rd_slot, a_wr_slot, clr_slot;
    logic [2:0]  u_row, u_col, u_dim_m, u_dim_n, u_cur_m, u_cur_n;
    logic [2:0]  a_rd_row, a_rd_col, a_cur_m, a_cur_n, a_wr_row, a_wr_col, a_res_m, a_res_n;
    logic [15:0] u_wdata, u_rdata, a_rdata, a_wdata;
    logic        u_we, u_re, u_rvalid, u_dim_we, a_re, a_rvalid, a_we, a_dim_we;
    logic        clr_req, clr_busy, err_oob;
    logic [3:0]  slot_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    always #5 clk = ~clk;

    matrix_mem_banked dut (
        .clk (clk), .rst_n (rst_n),
        .u_slot_i (u_slot), .u_row_i (u_row), .u_col_i (u_col), .u_wdata_i (u_wdata),
        .u_we_i (u_we), .u_re_i (u_re), .u_rdata_o (u_rdata), .u_rvalid_o (u_rvalid),
        .u_dim_m_i (u_dim_m), .u_dim_n_i (u_dim_n), .u_dim_we_i (u_dim_we),
        .u_cur_m_o (u_cur_m), .u_cur_n_o (u_cur_n),
        .a_rd_slot_i (a_rd_slot), .a_rd_row_i (a_rd_row), .a_rd_col_i (a_rd_col),
        .a_re_i (a_re), .a_rdata_o (a_rdata), .a_rvalid_o (a_rvalid),
        .a_cur_m_o (a_cur_m), .a_cur_n_o (a_cur_n),
        .a_wr_slot_i (a_wr_slot), .a_wr_row_i (a_wr_row), .a_wr_col_i (a_wr_col),
        .a_wdata_i (a_wdata), .a_we_i (a_we), .a_res_m_i (a_res_m), .a_res_n_i (a_res_n),
        .a_dim_we_i (a_dim_we), .clr_req_i (clr_req), .clr_slot_i (clr_slot),
        .clr_busy_o (clr_busy), .slot_valid_o (slot_valid), .err_oob_o (err_oob)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic u_read(input int s, input int r, input int c);
        u_slot = 2'(s); u_row = 3'(r); u_col = 3'(c); u_re = 1'b1;
        tick();
        u_re = 1'b0;
    endtask

    task automatic a_write(input int s, input int r, input int c, input logic [15:0] d);
        a_wr_slot = 2'(s); a_wr_row = 3'(r); a_wr_col = 3'(c); a_wdata = d; a_we = 1'b1;
        tick();
        a_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        u_slot = '0; u_row = '0; u_col = '0; u_wdata = '0; u_we = 0; u_re = 0;
        u_dim_m = '0; u_dim_n = '0; u_dim_we = 0;
        a_rd_slot = '0; a_rd_row = '0; a_rd_col = '0; a_re = 0;
        a_wr_slot = '0; a_wr_row = '0; a_wr_col = '0; a_wdata = '0; a_we = 0;
        a_res_m = '0; a_res_n = '0; a_dim_we = 0; clr_req = 0; clr_slot = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_u_rvalid", 32'(u_rvalid), 0);
        check("rst_u_rdata", 32'(u_rdata), 0);
        check("rst_clr_busy", 32'(clr_busy), 0);
        check("rst_slot_valid", 32'(slot_valid), 0);
        check("rst_err_oob", 32'(err_oob), 0);
        check("rst_u_cur_m", 32'(u_cur_m), 0);

        // Neighbouring addresses 74 (slot2,4,4) and 75 (slot3,0,0)
        u_slot = 2'd3; u_row = 3'd0; u_col = 3'd0; u_wdata = 16'hBEEF; u_we = 1'b1;
        tick();
        u_slot = 2'd2; u_row = 3'd4; u_col = 3'd4; u_wdata = 16'h1234;
        tick();
        u_we = 1'b0;
        u_read(2, 4, 4);
        check("u_rvalid_pulse", 32'(u_rvalid), 1);
        check("u_rdata_s2_44", 32'(u_rdata), 32'h1234);
        tick();
        check("u_rvalid_drop", 32'(u_rvalid), 0);
        check("u_rdata_hold", 32'(u_rdata), 32'h1234);
        a_rd_slot = 2'd3; a_rd_row = 3'd0; a_rd_col = 3'd0; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        check("a_rvalid_pulse", 32'(a_rvalid), 1);
        check("a_rdata_s3_00", 32'(a_rdata), 32'hBEEF);

        // ALU beats user at the same address
        u_slot = 2'd1; u_row = 3'd0; u_col = 3'd0; u_wdata = 16'h0001; u_we = 1'b1;
        a_wr_slot = 2'd1; a_wr_row = 3'd0; a_wr_col = 3'd0; a_wdata = 16'h0002; a_we = 1'b1;
        tick();
        u_we = 1'b0; a_we = 1'b0;
        u_read(1, 0, 0);
        check("prio_alu_over_user", 32'(u_rdata), 32'h0002);

        // Read-before-write
        a_wr_slot = 2'd1; a_wr_row = 3'd0; a_wr_col = 3'd0; a_wdata = 16'h0003; a_we = 1'b1;
        u_read(1, 0, 0);
        a_we = 1'b0;
        check("rbw_old_data", 32'(u_rdata), 32'h0002);
        u_read(1, 0, 0);
        check("rbw_new_data", 32'(u_rdata), 32'h0003);

        // Dimensions
        u_slot = 2'd0; u_dim_m = 3'd3; u_dim_n = 3'd2; u_dim_we = 1'b1;
        tick();
        u_dim_we = 1'b0;
        check("dim_u_cur_m", 32'(u_cur_m), 3);
        check("dim_u_cur_n", 32'(u_cur_n), 2);
        check("dim_slot_valid", 32'(slot_valid), 32'b0001);
        check("dim_no_err", 32'(err_oob), 0);
        u_slot = 2'd1; u_dim_m = 3'd1; u_dim_n = 3'd1; u_dim_we = 1'b1;
        a_wr_slot = 2'd1; a_res_m = 3'd4; a_res_n = 3'd5; a_dim_we = 1'b1;
        a_rd_slot = 2'd1;
        tick();
        u_dim_we = 1'b0; a_dim_we = 1'b0;
        check("dim_prio_a_cur_m", 32'(a_cur_m), 4);
        check("dim_prio_a_cur_n", 32'(a_cur_n), 5);
        check("dim_slot_valid2", 32'(slot_valid), 32'b0011);

        // Row 5 of slot 0 would alias slot 1 (0,0) if not dropped
        u_slot = 2'd0; u_row = 3'd5; u_col = 3'd0; u_wdata = 16'hDEAD; u_we = 1'b1;
        tick();
        u_we = 1'b0;
        check("oob_wr_err", 32'(err_oob), 1);
        u_read(1, 0, 0);
        check("oob_wr_dropped", 32'(u_rdata), 32'h0003);
        u_read(0, 7, 0);
        check("oob_rd_valid", 32'(u_rvalid), 1);
        check("oob_rd_zero", 32'(u_rdata), 0);

        // Clear slot 1
        for (int i = 0; i < 25; i++) a_write(1, i / 5, i % 5, 16'(16'h0100 + i));
        u_read(1, 2, 3);
        check("fill_s1_23", 32'(u_rdata), 32'h010D);
        clr_slot = 2'd1; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_req_clears_err", 32'(err_oob), 0);
        cnt = 0;
        while (clr_busy && cnt < 40) begin
            cnt++;
            if (cnt == 10) begin
                u_slot = 2'd1; u_row = 3'd0; u_col = 3'd1; u_wdata = 16'hFFFF; u_we = 1'b1;
                a_wr_slot = 2'd0; a_wr_row = 3'd1; a_wr_col = 3'd1; a_wdata = 16'h5A5A; a_we = 1'b1;
            end else begin
                u_we = 1'b0; a_we = 1'b0;
            end
            tick();
        end
        u_we = 1'b0; a_we = 1'b0;
        check("clr_busy_cycles", 32'(cnt), 26);
        for (int i = 0; i < 25; i++) begin
            u_read(1, i / 5, i % 5);
            check($sformatf("clr_s1_elem%0d", i), 32'(u_rdata), 0);
        end
        check("clr_slot_valid", 32'(slot_valid), 32'b0001);
        u_slot = 2'd1;
        #1;
        check("clr_dim_m_zero", 32'(u_cur_m), 0);
        u_read(0, 1, 1);
        check("clr_other_slot_wr", 32'(u_rdata), 32'h5A5A);

        // Oversized dimension
        u_slot = 2'd0; u_dim_m = 3'd6; u_dim_n = 3'd1; u_dim_we = 1'b1;
        tick();
        u_dim_we = 1'b0;
        check("dim_big_err", 32'(err_oob), 1);
        check("dim_big_dropped", 32'(u_cur_m), 3);

        // Reset ten cycles into a clear of slot 2
        for (int i = 0; i < 25; i++) a_write(2, i / 5, i % 5, 16'(16'h0200 + i));
        clr_slot = 2'd2; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr2_busy", 32'(clr_busy), 1);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(clr_busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 25; i++) begin
            u_read(2, i / 5, i % 5);
            check($sformatf("partial_s2_elem%0d", i), 32'(u_rdata),
                  (i < 10) ? 32'h0 : 32'(16'h0200 + i));
        end
        clr_slot = 2'd2; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_after_rst_busy", 32'(clr_busy), 1);
        cnt = 0;
        while (clr_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check("clr_after_rst_cycles", 32'(cnt), 26);
        u_read(2, 4, 4);
        check("clr_after_rst_elem24", 32'(u_rdata), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_mem_banked.md
Name: matrix_mem_banked

Overview:
- Parametrised successor to the CalcKit matrix storage block: NUM_SLOTS matrices of up to MAX_DIM x MAX_DIM elements, each DATA_W bits wide, with per-slot dimensions and valid flags.
- Dual-ported: a user port for entry and display, and an ALU port for operand fetch and result write-back.
- Reads are registered with a valid strobe. Writes use fixed arbitration. A slot-clear engine zeroes a whole slot in the background.
- Sits between the input/display FSMs and the matrix ALU.

Parameters:
- DATA_W, 16, element width in bits.
- NUM_SLOTS, 4, number of matrix slots.
- MAX_DIM, 5, maximum rows and maximum columns per matrix.
- SLOT_W, 2, slot index width; must satisfy 2^SLOT_W >= NUM_SLOTS.
- DIM_W, 3, row/col/dimension width; must satisfy 2^DIM_W > MAX_DIM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- u_slot  in  SLOT_W  user slot index
- u_row, u_col  in  DIM_W each  user element coordinates
- u_wdata  in  DATA_W  user write data
- u_we  in  1  user element write
- u_re  in  1  user read request
- u_rdata  out  DATA_W  user read data, registered
- u_rvalid  out  1  u_rdata valid, one-cycle pulse
- u_dim_m, u_dim_n  in  DIM_W each  user dimensions to store
- u_dim_we  in  1  user dimension write
- u_cur_m, u_cur_n  out  DIM_W each  dimensions of u_slot, combinational
- a_rd_slot, a_rd_row, a_rd_col  in  SLOT_W/DIM_W/DIM_W  ALU read address
- a_re  in  1  ALU read request
- a_rdata  out  DATA_W  ALU read data, registered
- a_rvalid  out  1  a_rdata valid, one-cycle pulse
- a_cur_m, a_cur_n  out  DIM_W each  dimensions of a_rd_slot, combinational
- a_wr_slot, a_wr_row, a_wr_col  in  SLOT_W/DIM_W/DIM_W  ALU write address
- a_wdata  in  DATA_W  ALU write data
- a_we  in  1  ALU element write
- a_res_m, a_res_n  in  DIM_W each  ALU result dimensions
- a_dim_we  in  1  ALU dimension write
- clr_req  in  1  start a slot clear (single-cycle pulse)
- clr_slot  in  SLOT_W  slot to clear
- clr_busy  out  1  clear engine active
- slot_valid  out  NUM_SLOTS  per-slot "dimensions written" flags
- err_oob  out  1  sticky out-of-range flag; cleared by reset or by clr_req

Behaviour:
- Storage layout: addr = slot*MAX_DIM*MAX_DIM + row*MAX_DIM + col. Compute in a width of ceil(log2(NUM_SLOTS*MAX_DIM^2)) + 1 bits so no partial product is truncated.
- Out-of-range access: any access with row >= MAX_DIM, col >= MAX_DIM or slot >= NUM_SLOTS is out of range.
  - OOB write is dropped and sets err_oob.
  - OOB read returns 0 with the valid strobe and sets err_oob.
- Reset values: all outputs 0; dims 0; slot_valid 0; FSM in IDLE. Element contents are not reset.
- Reads: u_re/a_re sampled at edge N; data and rvalid appear at edge N+1.
  - rdata holds its value until the next read.
  - A same-cycle write to the same address returns the OLD data (read-before-write).
- Write priority at one address in the same cycle: clear engine > ALU > user. The same ordering applies to dimension writes targeting the same slot.
- Dimension write: stores m and n for the slot and sets slot_valid[slot]. Values above MAX_DIM are dropped and set err_oob.
- Clear FSM:
  - IDLE: on clr_req, latch clr_slot, set idx=0, go to CLEAR, assert clr_busy on the next cycle.
  - CLEAR: each cycle write 0 to element idx of the latched slot, then idx++. When idx reaches MAX_DIM^2-1, write it, then go to DONE.
  - DONE: one cycle. Zero dims_m/dims_n of the slot, clear slot_valid[slot], drop clr_busy, return to IDLE.
  - Total clr_busy high time is MAX_DIM^2+1 cycles.
  - clr_req while busy is ignored.
  - User/ALU writes (element or dimension) to the slot being cleared are dropped while busy.
  - Reads and writes to other slots proceed normally.
  - Reads from the slot being cleared return whatever is currently stored.
- rst_n low at any time, including mid-clear: FSM goes to IDLE immediately, clr_busy=0, and the partially cleared slot keeps its remaining contents.

Decomposition:
- Shared package calckit_pkg holds DATA_W, NUM_SLOTS, MAX_DIM, SLOT_W and DIM_W defaults, the clear FSM state enum (IDLE/CLEAR/DONE), and an addr_of(slot,row,col) function used here and in the ALU.
- One natural sub-module is matrix_clr_engine: the FSM, the index counter and the busy signal, driving a zero-write port into the bank.

Test Plan:
- User writes 0x1234 to slot 2, (4,4); then u_re at slot 2, (4,4) -> u_rvalid one cycle later with u_rdata=0x1234. Slot 3, (0,0) is unchanged (no aliasing at the row*5 boundary).
- Same cycle: user writes 0x0001 and ALU writes 0x0002 to slot 1, (0,0) -> reading it back gives 0x0002.
- u_dim_we with m=3, n=2 on slot 0 -> u_cur_m=3, u_cur_n=2 and slot_valid=4'b0001. A dimension write with m=6 -> dropped and err_oob=1.
- Fill slot 1 with nonzero data, pulse clr_req for slot 1 -> clr_busy high for exactly 26 cycles. Afterwards all 25 elements read 0, slot_valid[1]=0, and a slot-0 write issued mid-clear persists.
- Write to row 5 -> dropped and err_oob=1. Read at row 7 -> u_rdata=0 with u_rvalid=1.
- Assert rst_n low 10 cycles into a clear -> clr_busy=0 immediately. Elements at idx >= 10 keep their old data, and a new clr_req after reset is accepted.
